// File: rtl/disp_scan_ctrl.sv
`timescale 1ns / 1ps
// disp_scan_ctrl: time-multiplexed scan controller and 7-segment driver.
//
// Generates the digit select for the upstream digit mux, decodes the returned hex
// digit to segments and drives one anode per slot. Every slot opens with a blanking
// interval (all anodes off) so the select can change and the mux settle while dark,
// which keeps the previous digit from ghosting onto the next.
//
// Ports:
//   CLK        system clock
//   RST        synchronous reset, active-high
//   EN         scan enable; low forces the display dark and holds the scan position
//   LZ_BLANK   suppress the most-significant digit when its value is 0
//   DIGIT      hex value of the currently selected digit
//   SEL        digit index 0..NUM_DIG-1 presented to the digit mux
//   AN         digit anodes, active-low, at most one low
//   SEG        segments {g,f,e,d,c,b,a}, active-low
//   FRAME_DONE one-cycle pulse when a full scan of all digits completes
module disp_scan_ctrl #(
    parameter int unsigned CLK_DIV   = 100000,
    parameter int unsigned BLANK_CYC = 16,
    parameter int unsigned NUM_DIG   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       LZ_BLANK,
    input  logic [3:0] DIGIT,
    output logic [1:0] SEL,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       FRAME_DONE
);

    localparam int unsigned     CntW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntShow   = CntW'(BLANK_CYC - 1);
    localparam logic [1:0]      SelLast   = 2'(NUM_DIG - 1);
    // A lone digit is never suppressed, so leading-zero blanking needs two or more.
    localparam logic            LzAllowed = (NUM_DIG > 1);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            fd_q, fd_d;
    logic            lz_hit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h7F;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        // Dark by default; only the SHOW path lights a digit.
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        an_d    = 4'b1111;
        seg_d   = 7'h7F;
        fd_d    = 1'b0;
        lz_hit  = LzAllowed && LZ_BLANK && (sel_q == SelLast) && (DIGIT == 4'h0);

        if (!EN) begin
            // Hold SEL; restart the slot so re-enable begins with a full blank interval.
            cnt_d   = '0;
            state_d = StBlank;
        end else if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StBlank;
            sel_d   = (sel_q == SelLast) ? 2'd0 : sel_q + 2'd1;
            fd_d    = (sel_q == SelLast);
        end else begin
            cnt_d = cnt_q + CntW'(1);
            if ((state_q == StShow) || (cnt_q == CntShow)) begin
                state_d = StShow;
                if (!lz_hit) begin
                    an_d[sel_q] = 1'b0;
                    seg_d       = decode(DIGIT);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fd_q    <= fd_d;
        end
    end

    assign SEL        = sel_q;
    assign AN         = an_q;
    assign SEG        = seg_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
`timescale 1ns / 1ps
// Bench for disp_scan_ctrl with a behavioural two-input digit mux in front of DIGIT.
// Stimulus pushes cycle-tagged expectations; a negedge monitor pops and compares them
// and also checks the anode/select invariants every cycle.
module tb_disp_scan_ctrl;

    localparam int unsigned ClkDiv   = 8;
    localparam int unsigned BlankCyc = 2;
    localparam int unsigned NumDig   = 2;

    logic       clk = 1'b0;
    logic       rst, en, lz;
    logic [3:0] d_in0, d_in1, digit;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;

    // Digit mux model.
    assign digit = (sel == 2'd1) ? d_in1 : d_in0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .CLK_DIV  (ClkDiv),
        .BLANK_CYC(BlankCyc),
        .NUM_DIG  (NumDig)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .LZ_BLANK  (lz),
        .DIGIT     (digit),
        .SEL       (sel),
        .AN        (an),
        .SEG       (seg),
        .FRAME_DONE(fd)
    );

    typedef struct packed {
        int         tgt;
        logic [7:0] scen;
        logic [7:0] cyc_n;
        logic [1:0] sel;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         base = 0;
    int         scen = 0;
    int         checks = 0;
    int         errors = 0;
    logic       prop_en = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    logic [6:0] seg_tbl [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < base + n - 1) step(1);
    endtask

    task automatic expect_at(input int n, input logic [1:0] s, input logic [3:0] a,
                             input logic [6:0] g, input logic f);
        exp_t e;
        e.tgt   = base + n - 1;
        e.scen  = 8'(scen);
        e.cyc_n = 8'(n);
        e.sel   = s;
        e.an    = a;
        e.seg   = g;
        e.fd    = f;
        exp_q.push_back(e);
    endtask

    // Reference sequence after reset with DIGIT0=3, DIGIT1=A, no suppression.
    task automatic push_s1();
        expect_at(1,  2'd0, 4'b1111, 7'h7F, 1'b0);
        expect_at(2,  2'd0, 4'b1111, 7'h7F, 1'b0);
        expect_at(3,  2'd0, 4'b1110, 7'h30, 1'b0);
        expect_at(8,  2'd0, 4'b1110, 7'h30, 1'b0);
        expect_at(9,  2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(10, 2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(11, 2'd1, 4'b1101, 7'h08, 1'b0);
        expect_at(16, 2'd1, 4'b1101, 7'h08, 1'b0);
        expect_at(17, 2'd0, 4'b1111, 7'h7F, 1'b1);
        expect_at(18, 2'd0, 4'b1111, 7'h7F, 1'b0);
    endtask

    always @(negedge clk) begin
        if (prop_en) begin
            checks++;
            if (an[3:2] != 2'b11 || $countones(~an) > 1 || sel > 2'd1) begin
                errors++;
                $display("FAIL anode_invariant cyc %0d got sel=%0d an=%b want one-hot-low an, sel<=1",
                         cyc, sel, an);
            end
            if (sel != prev_sel) begin
                checks++;
                if (an != 4'b1111) begin
                    errors++;
                    $display("FAIL sel_change_dark cyc %0d got an=%b want an=1111", cyc, an);
                end
            end
        end
        prev_sel = sel;
        for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].tgt < cyc) begin
                checks++;
                errors++;
                $display("FAIL s%0d.c%0d missed (target %0d, now %0d)",
                         exp_q[i].scen, exp_q[i].cyc_n, exp_q[i].tgt, cyc);
                exp_q.delete(i);
            end else if (exp_q[i].tgt == cyc) begin
                checks++;
                if ({sel, an, seg, fd} !== {exp_q[i].sel, exp_q[i].an, exp_q[i].seg, exp_q[i].fd})
                begin
                    errors++;
                    $display("FAIL s%0d.c%0d sel/an/seg/fd got %0d/%b/%h/%b want %0d/%b/%h/%b",
                             exp_q[i].scen, exp_q[i].cyc_n, sel, an, seg, fd,
                             exp_q[i].sel, exp_q[i].an, exp_q[i].seg, exp_q[i].fd);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst   = 1'b1;
        en    = 1'b0;
        lz    = 1'b0;
        d_in0 = 4'h3;
        d_in1 = 4'hA;
        step(3);
        en = 1'b1;

        // 1: basic scan after reset.
        scen = 1;
        do_reset();
        prop_en = 1'b1;
        push_s1();
        goto_cyc(19);

        // 2: ten free-running frames under the monitor invariants.
        scen = 2;
        step(160);

        // 3: leading-zero suppression of the top digit, then digit becomes 5 mid-slot.
        scen  = 3;
        lz    = 1'b1;
        d_in1 = 4'h0;
        do_reset();
        expect_at(3,  2'd0, 4'b1110, 7'h30, 1'b0);
        expect_at(9,  2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(11, 2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(13, 2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(14, 2'd1, 4'b1101, 7'h12, 1'b0);
        expect_at(16, 2'd1, 4'b1101, 7'h12, 1'b0);
        expect_at(17, 2'd0, 4'b1111, 7'h7F, 1'b1);
        goto_cyc(13);
        d_in1 = 4'h5;
        goto_cyc(18);
        lz    = 1'b0;
        d_in1 = 4'hA;

        // 4: decode sweep of digit 0, four values per slot-0 SHOW window.
        scen = 4;
        do_reset();
        for (int v = 0; v < 16; v++) begin
            c = 16 * (v / 4) + 3 + (v % 4);
            goto_cyc(c);
            d_in0 = 4'(v);
            expect_at(c + 1, 2'd0, 4'b1110, seg_tbl[v], 1'b0);
        end
        goto_cyc(57);
        d_in0 = 4'h3;

        // 5: disable mid-SHOW of slot 1, re-enable resumes at the held select.
        scen = 5;
        do_reset();
        expect_at(12, 2'd1, 4'b1101, 7'h08, 1'b0);
        expect_at(13, 2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(15, 2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(16, 2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(17, 2'd1, 4'b1111, 7'h7F, 1'b0);
        expect_at(18, 2'd1, 4'b1101, 7'h08, 1'b0);
        expect_at(23, 2'd1, 4'b1101, 7'h08, 1'b0);
        expect_at(24, 2'd0, 4'b1111, 7'h7F, 1'b1);
        expect_at(35, 2'd1, 4'b1101, 7'h08, 1'b0);
        goto_cyc(12);
        en = 1'b0;
        goto_cyc(16);
        en = 1'b1;
        goto_cyc(35);

        // 6: reset mid-slot 1 restarts the scan cleanly.
        scen = 6;
        do_reset();
        push_s1();
        goto_cyc(19);

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller and 7-segment driver for the seven-segment digit display.
- Sits directly downstream of dispmux: generates dispmux's SEL, consumes its 4-bit D_OUT as DIGIT, decodes it to segments and drives the digit anodes.
- Inserts a blanking gap at every digit change so the previous digit never ghosts onto the next.

Parameters:
- CLK_DIV, 100000: clock cycles per digit slot. Requires CLK_DIV ≥ BLANK_CYC+2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off. Requires ≥ 1.
- NUM_DIG, 2: number of digits scanned, range 1..4.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous reset, active-high
- EN  input  1  scan enable; low forces display dark and holds the scan
- LZ_BLANK  input  1  1 = suppress the most-significant digit (index NUM_DIG-1) when its value is 0
- DIGIT  input  4  hex value of the selected digit (dispmux D_OUT)
- SEL  output  2  digit index to dispmux, 0..NUM_DIG-1
- AN  output  4  digit anodes, active-low, one-hot low; bits ≥ NUM_DIG always 1
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low
- FRAME_DONE  output  1  one-cycle pulse when a full scan of all digits completes

Behaviour:
- All outputs are registered.
- Reset (RST=1 at a rising edge) forces:
  - cnt=0, state=BLANK, SEL=0, AN=4'b1111, SEG=7'h7F, FRAME_DONE=0.
  - Reset applies mid-slot or mid-frame with no residue.
- Slot counter cnt runs 0..CLK_DIV-1 and increments every cycle while EN=1.
- State BLANK, entered when cnt wraps CLK_DIV-1→0:
  - On that edge: AN←4'b1111, SEG←7'h7F, SEL←SEL+1, wrapping from NUM_DIG-1 to 0.
  - SEL therefore changes only while dark, giving dispmux a full blank interval to settle.
- State SHOW, entered on the edge where cnt goes BLANK_CYC-1→BLANK_CYC:
  - AN[SEL]←0, all other anode bits 1.
  - Every cycle in SHOW: SEG←decode(DIGIT). Latency DIGIT→SEG is 1 cycle.
  - Exception: if LZ_BLANK=1, SEL=NUM_DIG-1 and DIGIT=0, then AN stays 4'b1111 and SEG=7'h7F for that cycle.
  - When NUM_DIG=1, LZ_BLANK has no effect; a single digit is never suppressed.
- FRAME_DONE:
  - High for exactly the cycle after the edge where the slot with SEL=NUM_DIG-1 ends, i.e. coincident with SEL returning to 0.
  - With NUM_DIG=1, it pulses every slot.
- Decode table, hex digit → SEG:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- EN=0:
  - On the next edge: cnt←0, state←BLANK, AN←1111, SEG←7F, FRAME_DONE←0. SEL holds its value.
  - On re-enable, the scan resumes at the held SEL with a full blank interval first, and no SEL advance on that first slot.
- Simultaneous events: RST overrides EN. EN=0 overrides slot wrap and the SHOW transition.
- DIGIT changing mid-SHOW is reflected on SEG one cycle later. No glitch filtering.
- SEL never exceeds NUM_DIG-1, even across reset or EN toggling.

Test Plan:
Bench parameters: CLK_DIV=8, BLANK_CYC=2, NUM_DIG=2, 10 ns clock, dispmux instantiated with D_IN0=4'h3, D_IN1=4'hA, SEL connected, D_OUT→DIGIT.
1. Reset then EN=1, LZ_BLANK=0:
   - AN=1111 and SEG=7F for cycles 1–2.
   - From cycle 3: AN=1110, SEG=30.
   - At cycle 9: SEL=1, AN=1111.
   - From cycle 11: AN=1101, SEG=08.
   - FRAME_DONE high for one cycle at cycle 17, with SEL=0.
2. Full-frame check: AN is never 0 in two bits at once, and SEL changes only when AN=1111, over 10 frames.
3. LZ_BLANK=1 with D_IN1=0:
   - Slot 1 keeps AN=1111 and SEG=7F throughout.
   - Slot 0 still shows SEG=30.
   - With D_IN1=5, slot 1 shows SEG=12.
4. Sweep D_IN0 over 0..F: SEG matches the decode table one cycle after DIGIT changes within SHOW.
5. EN=0 asserted mid-SHOW of slot 1:
   - Next cycle: AN=1111, SEL holds 1.
   - After re-enable: 2 blank cycles, then AN=1101 with no intervening SEL change.
6. RST pulsed mid-slot 1: the next cycle shows SEL=0, AN=1111, SEG=7F, FRAME_DONE=0, and the scan restarts as in scenario 1.
